// File: rtl/pipeline_ctrl.sv
// Issue/hazard controller between decode and EX for the rv32i in-order pipeline.
// Tracks in-flight writers, stalls on RAW hazards, sequences redirect flushes.
module pipeline_ctrl #(
  parameter int DEPTH        = 3,
  parameter bit FWD_EN       = 1'b1,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        id_valid_i,
  input  logic [4:0]  id_opcode_i,
  input  logic [4:0]  id_rd_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        ex_ready_i,
  input  logic        redirect_i,
  output logic        issue_o,
  output logic        if_stall_o,
  output logic        id_stall_o,
  output logic        flush_o,
  output logic [1:0]  state_o,
  output logic [15:0] stall_count_o
);

  localparam logic [4:0] OP_LOAD    = 5'b00000;
  localparam logic [4:0] OP_ALU_IMM = 5'b00100;
  localparam logic [4:0] OP_AUIPC   = 5'b00101;
  localparam logic [4:0] OP_STORE   = 5'b01000;
  localparam logic [4:0] OP_ALU     = 5'b01100;
  localparam logic [4:0] OP_LUI     = 5'b01101;
  localparam logic [4:0] OP_BRANCH  = 5'b11000;
  localparam logic [4:0] OP_JALR    = 5'b11001;
  localparam logic [4:0] OP_JAL     = 5'b11011;

  // Counter holds remaining flush cycles beyond the first two (redirect + first FLUSH).
  localparam int CW = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES - 1) : 1;
  localparam logic [CW-1:0] FLUSH_LOAD = CW'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);

  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
    logic       is_load;
  } sb_ent_t;

  typedef enum logic [1:0] {
    ST_RESET = 2'b00,
    ST_RUN   = 2'b01,
    ST_STALL = 2'b10,
    ST_FLUSH = 2'b11
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       fcnt_q, fcnt_d;
  sb_ent_t [DEPTH-1:0] sb_q, sb_d;
  logic [15:0]         scnt_q, scnt_d;

  logic rd_rs1, rd_rs2, wr_rd, hazard;

  always_comb begin
    rd_rs1 = 1'b0;
    rd_rs2 = 1'b0;
    wr_rd  = 1'b0;
    unique case (id_opcode_i)
      OP_ALU:              begin rd_rs1 = 1'b1; rd_rs2 = 1'b1; wr_rd = 1'b1; end
      OP_ALU_IMM, OP_LOAD,
      OP_JALR:             begin rd_rs1 = 1'b1; wr_rd = 1'b1; end
      OP_STORE, OP_BRANCH: begin rd_rs1 = 1'b1; rd_rs2 = 1'b1; end
      OP_LUI, OP_AUIPC,
      OP_JAL:              wr_rd = 1'b1;
      default: ;
    endcase
  end

  // The last entry retires through the write-through register file, so it is not checked.
  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < DEPTH - 1; k++) begin
      if (sb_q[k].vld &&
          ((rd_rs1 && id_rs1_i != 5'd0 && id_rs1_i == sb_q[k].rd) ||
           (rd_rs2 && id_rs2_i != 5'd0 && id_rs2_i == sb_q[k].rd)) &&
          (!FWD_EN || (k == 0 && sb_q[k].is_load)))
        hazard = 1'b1;
    end
  end

  logic unused_sb_tail;
  assign unused_sb_tail = ^sb_q[DEPTH-1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_RESET;
      fcnt_q  <= '0;
      sb_q    <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      sb_q    <= sb_d;
      scnt_q  <= scnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (redirect_i) begin
      if (FLUSH_CYCLES > 1) begin
        state_d = ST_FLUSH;
        fcnt_d  = FLUSH_LOAD;
      end else begin
        state_d = ST_RUN;
      end
    end else begin
      unique case (state_q)
        ST_RESET: state_d = ST_RUN;
        ST_FLUSH: begin
          if (fcnt_q != '0) fcnt_d  = fcnt_q - CW'(1);
          else              state_d = ST_RUN;
        end
        default:  state_d = (id_valid_i && hazard) ? ST_STALL : ST_RUN;
      endcase
    end
  end

  always_comb begin
    flush_o    = redirect_i | (state_q == ST_FLUSH) | (state_q == ST_RESET);
    issue_o    = id_valid_i & ~hazard & ex_ready_i & ~redirect_i &
                 (state_q != ST_RESET) & (state_q != ST_FLUSH);
    if_stall_o = id_valid_i & ~issue_o & ~flush_o;
    id_stall_o = if_stall_o;
    state_o    = state_q;
  end

  // Scoreboard shifts only when EX accepts; backpressure freezes it so hazards persist.
  always_comb begin
    sb_d = sb_q;
    if (ex_ready_i) begin
      for (int k = 1; k < DEPTH; k++) sb_d[k] = sb_q[k-1];
      if (issue_o && wr_rd && id_rd_i != 5'd0) begin
        sb_d[0].vld     = 1'b1;
        sb_d[0].rd      = id_rd_i;
        sb_d[0].is_load = (id_opcode_i == OP_LOAD);
      end else begin
        sb_d[0] = '0;
      end
    end
  end

  always_comb begin
    scnt_d = scnt_q;
    if (state_d == ST_STALL && scnt_q != 16'hFFFF) scnt_d = scnt_q + 16'd1;
  end

  assign stall_count_o = scnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench: two controllers (forwarding and no forwarding) driven by directed
// per-cycle vectors; expected outputs are queued and checked by a negedge monitor.
module tb_pipeline_ctrl;

  localparam logic [4:0] LOAD  = 5'b00000;
  localparam logic [4:0] STORE = 5'b01000;
  localparam logic [4:0] ALU   = 5'b01100;
  localparam logic [4:0] LUI   = 5'b01101;

  typedef struct packed {
    logic       v;
    logic [4:0] op, rd, rs1, rs2;
    logic       rdy, redir;
  } in_t;

  typedef struct packed {
    logic        iss;
    logic [1:0]  stl;
    logic        fl;
    logic [1:0]  st;
    logic [15:0] cnt;
  } ex_t;

  typedef struct packed {
    ex_t a;
    ex_t b;
  } pair_t;

  logic clk = 1'b0;
  logic rst;
  in_t  ia, ib;
  always #5 clk = ~clk;

  logic        iss_a, ifs_a, ids_a, fl_a, iss_b, ifs_b, ids_b, fl_b;
  logic [1:0]  st_a, st_b;
  logic [15:0] cnt_a, cnt_b;

  pipeline_ctrl #(.DEPTH(3), .FWD_EN(1'b1), .FLUSH_CYCLES(2)) dut_a (
    .clk_i(clk), .rst_i(rst), .id_valid_i(ia.v), .id_opcode_i(ia.op), .id_rd_i(ia.rd),
    .id_rs1_i(ia.rs1), .id_rs2_i(ia.rs2), .ex_ready_i(ia.rdy), .redirect_i(ia.redir),
    .issue_o(iss_a), .if_stall_o(ifs_a), .id_stall_o(ids_a), .flush_o(fl_a),
    .state_o(st_a), .stall_count_o(cnt_a));

  pipeline_ctrl #(.DEPTH(3), .FWD_EN(1'b0), .FLUSH_CYCLES(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .id_valid_i(ib.v), .id_opcode_i(ib.op), .id_rd_i(ib.rd),
    .id_rs1_i(ib.rs1), .id_rs2_i(ib.rs2), .ex_ready_i(ib.rdy), .redirect_i(ib.redir),
    .issue_o(iss_b), .if_stall_o(ifs_b), .id_stall_o(ids_b), .flush_o(fl_b),
    .state_o(st_b), .stall_count_o(cnt_b));

  pair_t       q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc_n = 0;
  logic [15:0] acnt = 16'd0;
  logic [15:0] bcnt = 16'd0;

  function automatic in_t I(logic v, logic [4:0] op, logic [4:0] rd, logic [4:0] rs1,
                            logic [4:0] rs2, logic rdy = 1'b1, logic redir = 1'b0);
    in_t r;
    r.v = v; r.op = op; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.rdy = rdy; r.redir = redir;
    return r;
  endfunction

  function automatic ex_t E(logic iss, logic stl, logic fl, logic [1:0] st, logic [15:0] cnt);
    ex_t r;
    r.iss = iss; r.stl = {stl, stl}; r.fl = fl; r.st = st; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string name, input ex_t act, input ex_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle %0d: got iss=%b stl=%b fl=%b st=%b cnt=%0d, want iss=%b stl=%b fl=%b st=%b cnt=%0d",
               name, cyc_n, act.iss, act.stl, act.fl, act.st, act.cnt,
               exp.iss, exp.stl, exp.fl, exp.st, exp.cnt);
    end
  endtask

  always @(negedge clk) begin
    pair_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("dutA", {iss_a, ifs_a, ids_a, fl_a, st_a, cnt_a}, e.a);
      chk("dutB", {iss_b, ifs_b, ids_b, fl_b, st_b, cnt_b}, e.b);
      cyc_n++;
    end
  end

  // rl raises reset part-way through the cycle, before the monitor samples.
  task automatic cyc(input in_t a, input ex_t ea, input in_t b, input ex_t eb,
                     input logic r, input logic rl);
    pair_t p;
    rst = r; ia = a; ib = b;
    p.a = ea; p.b = eb;
    q.push_back(p);
    if (rl) begin #2; rst = 1'b1; end
    @(posedge clk); #1;
  endtask

  task automatic ca(input in_t a, input ex_t ea);
    cyc(a, ea, I(0, 0, 0, 0, 0), E(0, 0, 0, 2'b01, bcnt), 1'b0, 1'b0);
  endtask

  task automatic cb(input in_t b, input ex_t eb);
    cyc(I(0, 0, 0, 0, 0), E(0, 0, 0, 2'b01, acnt), b, eb, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    ia = I(0, 0, 0, 0, 0);
    ib = I(0, 0, 0, 0, 0);
    @(posedge clk); #1;

    // reset held, then first cycle after release still in RESET
    repeat (3) cyc(I(0,0,0,0,0), E(0,0,1,2'b00,0), I(0,0,0,0,0), E(0,0,1,2'b00,0), 1'b1, 1'b0);
    cyc(I(0,0,0,0,0), E(0,0,1,2'b00,0), I(0,0,0,0,0), E(0,0,1,2'b00,0), 1'b0, 1'b0);
    ca(I(0,0,0,0,0), E(0,0,0,2'b01,0));

    // load-use
    ca(I(1,LOAD,5,1,0),  E(1,0,0,2'b01,0));
    ca(I(1,ALU,6,5,2),   E(0,1,0,2'b01,0));
    ca(I(1,ALU,6,5,2),   E(1,0,0,2'b10,1));
    ca(I(0,0,0,0,0),     E(0,0,0,2'b01,1));
    // ALU-ALU with forwarding: no stall
    ca(I(1,ALU,5,1,2),   E(1,0,0,2'b01,1));
    ca(I(1,ALU,7,0,5),   E(1,0,0,2'b01,1));
    ca(I(0,0,0,0,0),     E(0,0,0,2'b01,1));
    // x0 destination and non-reading LUI
    ca(I(1,LOAD,0,1,0),  E(1,0,0,2'b01,1));
    ca(I(1,ALU,8,0,0),   E(1,0,0,2'b01,1));
    ca(I(1,LOAD,7,2,0),  E(1,0,0,2'b01,1));
    ca(I(1,LUI,7,7,7),   E(1,0,0,2'b01,1));
    ca(I(0,0,0,0,0),     E(0,0,0,2'b01,1));
    // load then store reading it through rs2
    ca(I(1,LOAD,9,2,0),  E(1,0,0,2'b01,1));
    ca(I(1,STORE,0,2,9), E(0,1,0,2'b01,1));
    ca(I(1,STORE,0,2,9), E(1,0,0,2'b10,2));
    ca(I(0,0,0,0,0),     E(0,0,0,2'b01,2));
    // redirect while a load-use hazard is pending
    ca(I(1,LOAD,4,1,0),        E(1,0,0,2'b01,2));
    ca(I(1,ALU,6,4,0,1'b1,1'b1), E(0,0,1,2'b01,2));
    ca(I(1,ALU,6,4,0),         E(0,0,1,2'b11,2));
    ca(I(0,0,0,0,0),           E(0,0,0,2'b01,2));
    // backpressure freezes the scoreboard
    ca(I(1,LOAD,3,1,0),        E(1,0,0,2'b01,2));
    ca(I(1,ALU,6,3,0,1'b0),    E(0,1,0,2'b01,2));
    ca(I(1,ALU,6,3,0,1'b0),    E(0,1,0,2'b10,3));
    ca(I(1,ALU,6,3,0,1'b0),    E(0,1,0,2'b10,4));
    ca(I(1,ALU,6,3,0,1'b0),    E(0,1,0,2'b10,5));
    ca(I(1,ALU,6,3,0),         E(0,1,0,2'b10,6));
    ca(I(1,ALU,6,3,0),         E(1,0,0,2'b10,7));
    ca(I(0,0,0,0,0),           E(0,0,0,2'b01,7));
    // backpressure without hazard is not counted
    ca(I(1,ALU,6,1,0,1'b0),    E(0,1,0,2'b01,7));
    ca(I(1,ALU,6,1,0),         E(1,0,0,2'b01,7));
    ca(I(0,0,0,0,0),           E(0,0,0,2'b01,7));

    // no forwarding: ALU-ALU stalls two cycles
    acnt = 16'd7;
    cb(I(1,ALU,5,1,2),   E(1,0,0,2'b01,0));
    cb(I(1,ALU,6,1,5),   E(0,1,0,2'b01,0));
    cb(I(1,ALU,6,1,5),   E(0,1,0,2'b10,1));
    cb(I(1,ALU,6,1,5),   E(1,0,0,2'b10,2));
    cb(I(0,0,0,0,0),     E(0,0,0,2'b01,2));
    cb(I(1,LOAD,0,1,0),  E(1,0,0,2'b01,2));
    cb(I(1,ALU,8,0,0),   E(1,0,0,2'b01,2));

    // async reset mid-stall clears the frozen scoreboard immediately
    bcnt = 16'd2;
    ca(I(1,LOAD,3,1,0),     E(1,0,0,2'b01,7));
    ca(I(1,ALU,6,3,0,1'b0), E(0,1,0,2'b01,7));
    cyc(I(1,ALU,6,3,0,1'b0), E(0,0,1,2'b00,0), I(0,0,0,0,0), E(0,0,1,2'b00,0), 1'b0, 1'b1);
    cyc(I(1,ALU,6,3,0),      E(0,0,1,2'b00,0), I(0,0,0,0,0), E(0,0,1,2'b00,0), 1'b0, 1'b0);
    bcnt = 16'd0;
    ca(I(1,ALU,6,3,0),      E(1,0,0,2'b01,0));
    ca(I(0,0,0,0,0),        E(0,0,0,2'b01,0));

    for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Issue and hazard controller for the rv32i in-order pipeline. It sits between the decode stage and EX. It checks each decoded instruction against a scoreboard of in-flight destination registers, and raises stalls on read-after-write hazards. It also sequences IF/ID flushes on branch/jump redirects and gates issue into EX under EX backpressure.

Parameters:
DEPTH, 3, number of stages from issue to register-file write (EX, MEM, WB); minimum 2.
FWD_EN, 1, 1 = full forwarding present, so only load-use stalls; 0 = no forwarding, so stall on any in-flight match.
FLUSH_CYCLES, 2, cycles flush_o stays asserted per redirect, counting the redirect cycle; minimum 1.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  reset, asynchronous, active-high.
id_valid_i  in  1  decode stage holds a valid decoded instruction.
id_opcode_i  in  5  decoded opcode, instruction bits [6:2], encoded per riscv_pkg OP_* constants.
id_rd_i  in  5  decoded rd.
id_rs1_i  in  5  decoded rs1.
id_rs2_i  in  5  decoded rs2.
ex_ready_i  in  1  EX accepts an instruction this cycle; when 0, the back end is frozen.
redirect_i  in  1  EX resolved a taken branch or jump this cycle.
issue_o  out  1  ID instruction transfers to EX at this clock edge.
if_stall_o  out  1  hold PC and IF/ID register.
id_stall_o  out  1  hold the decode output register.
flush_o  out  1  kill IF/ID contents (insert bubble).
state_o  out  2  FSM state: 00 RESET, 01 RUN, 10 STALL, 11 FLUSH.
stall_count_o  out  16  saturating count of hazard-stall cycles.

Behaviour:
Reset (async assert)
- state goes to RESET; scoreboard entries all invalid; flush counter 0; stall_count_o 0.
- Combinational outputs while rst_i high: issue_o 0, if_stall_o 0, id_stall_o 0, flush_o 1.

Operand and writer decode from id_opcode_i
- Reads rs1: ALU, ALU_IMM, LOAD, JALR, STORE, BRANCH.
- Reads rs2: ALU, STORE, BRANCH.
- Writes rd: ALU, ALU_IMM, LOAD, JALR, LUI, AUIPC, JAL.
- Reads and writes nothing: MISC_MEM, SYSTEM, unknown opcodes.
- Register x0 is never a hazard source and is never recorded.

Scoreboard
- DEPTH entries, each {valid, rd, is_load}; entry 0 = EX.
- Advances only on cycles where ex_ready_i=1.
  - Entry k+1 takes entry k.
  - Entry 0 takes {1, id_rd_i, opcode==LOAD} if issue_o, the opcode writes rd, and rd!=0; otherwise entry 0 becomes invalid.
- When ex_ready_i=0, all entries hold.
- Entry DEPTH-1 writes the register file at the end of the cycle; the register file is write-through, so entry DEPTH-1 is never checked.

Hazard (combinational)
- A source matches when it is read by the opcode, is non-zero, and equals the rd of a valid entry.
- FWD_EN=1: hazard = a source matches entry 0 and entry 0 is_load.
- FWD_EN=0: hazard = a source matches any valid entry 0..DEPTH-2.

Combinational outputs (registered scoreboard and state, current inputs)
- issue_o = id_valid_i & ~hazard & ex_ready_i & ~redirect_i & state!=RESET & state!=FLUSH.
- flush_o = redirect_i | state==FLUSH | state==RESET.
- id_stall_o = if_stall_o = id_valid_i & ~issue_o & ~flush_o.

FSM (registered), with priority in this order
1. redirect_i from any state: if FLUSH_CYCLES>1, go to FLUSH and load counter with FLUSH_CYCLES-2; else go to RUN.
2. RESET: go to RUN after one cycle.
3. FLUSH: while the counter is non-zero, decrement and stay; when it is 0, go to RUN. A new redirect in FLUSH reloads the counter.
4. RUN or STALL: go to STALL if id_valid_i & hazard, else go to RUN.

Stall counter
- stall_count_o increments on every clock where the next state is STALL.
- Saturates at 0xFFFF.
- Backpressure (ex_ready_i=0) without a hazard is not counted.

Boundaries
- Simultaneous hazard and redirect: redirect wins, with no issue and no stall.
- Stall under backpressure: entries freeze, so the hazard persists until EX drains.
- Async reset mid-stall or mid-flush: the scoreboard clears immediately.

Test Plan:
1. Reset: hold rst_i 3 cycles, then release → flush_o=1 and state_o=00 while in reset and for 1 cycle after release; then state_o=01 and stall_count_o=0.
2. Load-use, FWD_EN=1, ex_ready_i=1: issue LOAD rd=5, next cycle ALU rs1=5 → issue_o=0 and if/id_stall_o=1 for exactly 1 cycle, state_o=10, stall_count_o=1; issue_o=1 on the following cycle.
3. ALU-ALU dependency: ALU rd=5 followed by ALU rs2=5 → no stall with FWD_EN=1; 2 stall cycles with FWD_EN=0, DEPTH=3.
4. x0 and non-readers: LOAD rd=0 then ALU rs1=0, and LOAD rd=7 then LUI rd=7 → no stall in either case.
5. Redirect, FLUSH_CYCLES=2: assert redirect_i for 1 cycle while a hazard is pending → flush_o high for 2 cycles, issue_o=0 and stalls=0 throughout, state_o=11 then 01; stall_count_o unchanged.
6. Backpressure: LOAD rd=3 issued, ex_ready_i=0 for 4 cycles, dependent rs1=3 waiting → stalls held, scoreboard frozen, stall_count_o +4; after ex_ready_i=1, 1 more stall cycle, then issue.
